// File: rtl/data_mem_resp_if.sv
// CPU-side data memory bus: one request channel and one response channel.
interface data_mem_resp_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, wr, size, addr, wdata,
        input  addr_ok, data_ok, rdata, err
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output addr_ok, data_ok, rdata, err
    );
endinterface

// File: rtl/data_mem_resp.sv
// Single-outstanding data memory with fixed response latency.
// A request is taken in idle, held for LATENCY cycles, answered with a one-cycle
// data_ok strobe, and a write commits on the edge that closes the response cycle.
module data_mem_resp #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 2
) (
    input logic             clk,
    input logic             rst,
    data_mem_resp_if.slave  bus
);

    localparam int unsigned Words = 1 << ADDR_W;
    localparam logic [2:0]  LatM1 = 3'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e            state_q;
    logic [2:0]        cnt_q;
    logic              wr_q;
    logic [1:0]        size_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic              data_ok_q;

    logic [31:0]       mem [Words];

    logic              req_err;
    logic [ADDR_W-1:0] idx;
    logic [3:0]        be;

    // Misaligned or reserved-size requests are flagged at acceptance.
    always_comb begin
        req_err = (bus.size == 2'd3) ||
                  (bus.size == 2'd1 && bus.addr[0]) ||
                  (bus.size == 2'd2 && bus.addr[1:0] != 2'b00);
    end

    assign idx = addr_q[ADDR_W+1:2];

    // Byte-lane enables for the latched write.
    always_comb begin
        be = 4'b0000;
        unique case (size_q)
            2'd0:    be[addr_q[1:0]] = 1'b1;
            2'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
            2'd2:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Request FSM: latch on accept, count down the latency, strobe the response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= 3'd0;
            wr_q      <= 1'b0;
            size_q    <= 2'd0;
            addr_q    <= '0;
            wdata_q   <= 32'd0;
            err_q     <= 1'b0;
            data_ok_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.req) begin
                        wr_q    <= bus.wr;
                        size_q  <= bus.size;
                        addr_q  <= bus.addr[ADDR_W+1:0];
                        wdata_q <= bus.wdata;
                        err_q   <= req_err;
                        if (LATENCY > 1) begin
                            cnt_q   <= LatM1;
                            state_q <= StWait;
                        end else begin
                            cnt_q     <= 3'd0;
                            state_q   <= StResp;
                            data_ok_q <= 1'b1;
                        end
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q - 3'd1;
                    // Counter reaches zero on this edge.
                    if (cnt_q == 3'd1) begin
                        state_q   <= StResp;
                        data_ok_q <= 1'b1;
                    end
                end
                StResp: begin
                    state_q   <= StIdle;
                    data_ok_q <= 1'b0;
                end
                default: begin
                    state_q   <= StIdle;
                    data_ok_q <= 1'b0;
                end
            endcase
        end
    end

    // Storage is not reset; data_ok_q is already cleared if reset hits mid-flight.
    always_ff @(posedge clk) begin
        if (data_ok_q && wr_q && !err_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

    assign bus.addr_ok = (state_q == StIdle) && rst;
    assign bus.data_ok = data_ok_q;
    assign bus.err     = data_ok_q && err_q;
    assign bus.rdata   = (data_ok_q && !wr_q && !err_q) ? mem[idx] : 32'd0;

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 SHALL provide parameter ADDR_W, default 10, word-index width; storage is 2^ADDR_W 32-bit words.
REQ-002 SHALL provide parameter LATENCY, default 2, legal range 1..7; cycles from request acceptance to data_ok.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset (rst=0 resets).
REQ-005 SHALL have port req  input  1  CPU request valid.
REQ-006 SHALL have port wr  input  1  1=write, 0=read.
REQ-007 SHALL have port size  input  2  0=byte, 1=halfword, 2=word, 3=reserved.
REQ-008 SHALL have port addr  input  32  byte address.
REQ-009 SHALL have port wdata  input  32  write data, lane-aligned (byte/half already placed at lanes selected by addr[1:0]).
REQ-010 SHALL have port addr_ok  output  1  request accepted this cycle when req=1.
REQ-011 SHALL have port data_ok  output  1  one-cycle response strobe.
REQ-012 SHALL have port rdata  output  32  full aligned word read; valid only while data_ok=1.
REQ-013 SHALL have port err  output  1  response error flag; valid only while data_ok=1.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP; reset state IDLE.
REQ-015 SHALL drive addr_ok=1 only in IDLE; addr_ok is a function of state only, not of req.
REQ-016 SHALL accept a request on a rising edge where req=1 and addr_ok=1, latching wr, size, addr, wdata; one outstanding request maximum.
REQ-017 SHALL, on acceptance, load a down-counter with LATENCY-1 and go to WAIT if LATENCY>1, else directly to RESP.
REQ-018 SHALL in WAIT decrement the counter each cycle and go to RESP when it reaches 0; data_ok rises exactly LATENCY cycles after the accepting edge.
REQ-019 SHALL assert data_ok for exactly one cycle in RESP, then return to IDLE; next acceptance earliest one cycle after the data_ok cycle (throughput one per LATENCY+1 cycles).
REQ-020 SHALL ignore req and all request inputs outside IDLE; changes to them after acceptance do not affect the in-flight transaction.
REQ-021 SHALL index storage with latched addr[ADDR_W+1:2]; higher address bits ignored (aliasing/wrap-around at 2^ADDR_W words).
REQ-022 SHALL flag err=1 on: size=3; size=1 with addr[0]=1; size=2 with addr[1:0]!=0.
REQ-023 SHALL, for an err transaction, perform no storage write and return rdata=0.
REQ-024 SHALL derive byte enables: byte -> lane addr[1:0]; half -> lanes {1,0} if addr[1]=0 else {3,2}; word -> all four.
REQ-025 SHALL commit writes on the rising edge ending the RESP cycle, updating only enabled lanes; rdata for writes is 0.
REQ-026 SHALL for reads return the full word at the indexed location, sampled in the RESP cycle (includes all earlier completed writes); lane extraction/sign extension is the CPU's job.
REQ-027 SHALL hold data_ok=0, err=0, rdata=0 whenever not in RESP.

Reset
REQ-028 SHALL on rst=0 immediately force state IDLE, counter 0, data_ok=0, err=0, rdata=0, addr_ok=1 after reset release (addr_ok=0 while rst=0).
REQ-029 SHALL abort any in-flight transaction on reset with no storage write and no data_ok.
REQ-030 SHALL NOT reset storage contents; they are undefined until written.

Verification
REQ-031 SHALL cover: word write addr=0x10, wdata=0xDEADBEEF, then word read addr=0x10 -> data_ok 2 cycles after each accept, rdata=0xDEADBEEF, err=0.
REQ-032 SHALL cover: byte write addr=0x13, wdata=0xAA000000 onto word 0x11223344, half write addr=0x10 wdata=0x00005566, word read 0x10 -> rdata=0xAA225566.
REQ-033 SHALL cover: half read addr=0x21 and word read addr=0x22 and size=3 -> err=1, rdata=0, target word unchanged.
REQ-034 SHALL cover: req held high continuously with LATENCY=1 -> addr_ok pattern 1,0,1,0..., one data_ok per two cycles, no duplicate accepts.
REQ-035 SHALL cover: rst=0 asserted in WAIT of a word write 0x55555555 to addr 0x40 over prior 0x0 -> no data_ok, read of 0x40 after release returns 0x00000000.
REQ-036 SHALL cover: ADDR_W=10 write 0x12345678 to addr 0x1000 then read addr 0x0 -> rdata=0x12345678 (wrap-around).
